bin_to_digit_writer: RTL and testbench
======================================

// Module: bin_to_digit_writer
// PURPOSE
//  Upstream feeder for the 8-digit latched seven-segment display stage.
//  Accepts a binary value on a start strobe and converts it to 8 BCD digits
//  with sequential double-dabble, one shift per cycle.
//  Writes each digit into the display's per-digit latches over the
//  existing cs/data4/en write interface: cs selects the digit, data4 carries
//  the nibble, en strobes the write.
//  Runs in the display's clk domain; no CDC.
// PARAMETERS
//  BIN_W    27  width of bin_in; 2^27 covers the 99_999_999 display maximum
//  EN_W     2   cycles en is held high per digit write (>=1)
//  LZ_BLANK 0   1: leading zeros replaced by blank code 4'hF; digit 0 never blanked
// PORTS
//  clk     in   1      system clock, single clock domain
//  rst     in   1      synchronous reset, active-high
//  start   in   1      request; sampled only in IDLE
//  bin_in  in   BIN_W  value to display; captured on accepted start
//  busy    out  1      high from the cycle after accept until DONE inclusive
//  done    out  1      one-cycle pulse when all 8 digits have been written
//  ovf     out  1      captured value > 99_999_999; valid from CONV until next accept
//  cs      out  3      digit select to the display latches; 0 = least significant
//  data4   out  4      digit nibble to the display latches
//  en      out  1      latch write enable to the display latches
// BEHAVIOUR
//  Reset (rst=1 at posedge): state=IDLE.
//   Outputs cs=0, data4=0, en=0, busy=0, done=0, ovf=0.
//   Internal BCD/shift registers are cleared.
//   Reset mid-conversion or mid-write aborts the operation immediately.
//   Partially written digits keep their latched values; done does not fire.
//  State IDLE: en=0.
//   start=1 at edge k captures bin_in, clears the 32b BCD accumulator,
//   and moves to CONV.
//  State CONV: edges k+1 .. k+BIN_W, one iteration per edge.
//   Each iteration: add 3 to every BCD nibble >=5, then shift {bcd,bin}
//   left by 1.
//   ovf is computed combinationally from the captured value and registered
//   at the first CONV edge.
//  State WRITE: begins at edge k+BIN_W+1.
//   Digits are written in order cs=0..7.
//   Each digit takes EN_W+2 cycles: SETUP (en=0), EN_W strobe cycles (en=1),
//   HOLD (en=0).
//   cs and data4 stay stable for the whole digit slot, so the level-sensitive
//   latch captures clean data.
//   cs advances only at a slot boundary; cs wraps 7->0 only on leaving WRITE.
//  Digit value selection, in priority order:
//   ovf=1 -> 4'hE for all digits;
//   LZ_BLANK=1 and the digit plus all higher digits are zero, and cs!=0 -> 4'hF;
//   otherwise -> BCD nibble cs.
//  State DONE: entered after the last HOLD, at edge k+BIN_W+1+8*(EN_W+2).
//   Lasts 1 cycle with done=1 and busy=1, then returns to IDLE.
//  Timing for defaults: start accepted at k, done high in cycle
//   k+1+27+32 = k+60.
//  start while busy is ignored, not queued.
//   start on the same edge DONE->IDLE is ignored.
//   start on the first IDLE cycle after DONE is accepted.
//  bin_in changes after accept have no effect.
//  en is never high in IDLE, CONV or DONE, and never high while cs changes.
// TESTING
//  T1 bin_in=12_345_678, start pulse -> writes (cs,data4) = (0,8)(1,7)(2,6)
//     (3,5)(4,4)(5,3)(6,2)(7,1); done at k+60; ovf=0.
//  T2 bin_in=0, LZ_BLANK=0 -> all 8 writes data4=0.
//     LZ_BLANK=1 -> cs0 data4=0, cs1..7 data4=F.
//  T3 bin_in=100_000_000 -> ovf=1; all 8 writes data4=E; done still pulses.
//  T4 bin_in=99_999_999 (boundary) -> all digits 9, ovf=0.
//  T5 second start pulses during CONV and WRITE -> ignored; exactly one done.
//     start held high continuously -> back-to-back ops with one IDLE cycle
//     between them.
//  T6 rst asserted during digit 3 strobe -> next cycle en=0, cs=0, busy=0;
//     no done.
//     New start then completes normally.
//  Checker: en=1 implies cs/data4 unchanged since SETUP; en=0 outside WRITE.
//   Scoreboard models 8 latches and compares after each done.

Source files
------------

// File: rtl/bin_to_digit_writer.sv
// bin_to_digit_writer
// Converts a binary value to 8 BCD digits using a sequential double-dabble
// (one shift per cycle). It then writes each digit into the per-digit
// latches of the seven-segment display stage through the cs/data4/en
// interface.
// Ports:
//   clk, rst        clock and synchronous active-high reset
//   start, bin_in   request strobe (sampled in IDLE) and the value to convert
//   busy, done      operation in progress, and a one-cycle completion pulse
//   ovf             captured value exceeds 99_999_999 (all digits show 4'hE)
//   cs, data4, en   digit select, digit nibble and latch strobe
module bin_to_digit_writer #(
    parameter int unsigned BIN_W    = 27,
    parameter int unsigned EN_W     = 2,
    parameter int unsigned LZ_BLANK = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [BIN_W-1:0] bin_in,
    output logic             busy,
    output logic             done,
    output logic             ovf,
    output logic [2:0]       cs,
    output logic [3:0]       data4,
    output logic             en
);

    localparam int unsigned BCD_W   = 32;
    localparam int unsigned CNT_W   = $clog2(BIN_W + 1);
    localparam int unsigned PH_W    = $clog2(EN_W + 2);
    localparam int unsigned MAX_VAL = 99_999_999;
    localparam logic [PH_W-1:0]  PH_HOLD = PH_W'(EN_W + 1);
    localparam logic [CNT_W-1:0] CNT_END = CNT_W'(BIN_W);

    typedef enum logic [1:0] {S_IDLE, S_CONV, S_WRITE, S_DONE} state_t;

    state_t             state_q, state_nx;
    logic [CNT_W-1:0]   cnt_q, cnt_nx;
    logic [PH_W-1:0]    ph_q, ph_nx;
    logic [BCD_W-1:0]   bcd_q, bcd_nx, bcd_adj, upper;
    logic [BIN_W-1:0]   bin_q, bin_nx;
    logic [2:0]         cs_q, cs_nx;
    logic [3:0]         data4_q, data4_nx, nib;
    logic               en_q, en_nx, busy_q, busy_nx, done_q, done_nx;
    logic               ovf_q, ovf_nx, ovf_c;

    assign ovf_c = 64'(bin_q) > 64'(MAX_VAL);

    // State and registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            ph_q    <= '0;
            bcd_q   <= '0;
            bin_q   <= '0;
            cs_q    <= '0;
            data4_q <= '0;
            en_q    <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_nx;
            cnt_q   <= cnt_nx;
            ph_q    <= ph_nx;
            bcd_q   <= bcd_nx;
            bin_q   <= bin_nx;
            cs_q    <= cs_nx;
            data4_q <= data4_nx;
            en_q    <= en_nx;
            busy_q  <= busy_nx;
            done_q  <= done_nx;
            ovf_q   <= ovf_nx;
        end
    end

    // Next-state, datapath and output decode
    always_comb begin
        state_nx = state_q;
        cnt_nx   = cnt_q;
        ph_nx    = ph_q;
        bcd_nx   = bcd_q;
        bin_nx   = bin_q;
        cs_nx    = cs_q;
        data4_nx = data4_q;
        ovf_nx   = ovf_q;
        bcd_adj  = bcd_q;
        nib      = '0;
        upper    = '0;

        // Double-dabble correction: each nibble >= 5 gets +3 before the shift
        for (int i = 0; i < 8; i++) begin
            nib = bcd_q[4*i +: 4];
            if (nib >= 4'd5) begin
                bcd_adj[4*i +: 4] = nib + 4'd3;
            end
        end

        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    bin_nx   = bin_in;
                    bcd_nx   = '0;
                    cnt_nx   = '0;
                    ovf_nx   = 1'b0;
                    state_nx = S_CONV;
                end
            end
            S_CONV: begin
                if (cnt_q == CNT_END) begin
                    ph_nx    = '0;
                    cs_nx    = '0;
                    state_nx = S_WRITE;
                end else begin
                    // bin_q is still the captured value on the first iteration
                    if (cnt_q == '0) begin
                        ovf_nx = ovf_c;
                    end
                    bcd_nx = {bcd_adj[BCD_W-2:0], bin_q[BIN_W-1]};
                    bin_nx = {bin_q[BIN_W-2:0], 1'b0};
                    cnt_nx = cnt_q + CNT_W'(1);
                end
            end
            S_WRITE: begin
                if (ph_q == PH_HOLD) begin
                    ph_nx = '0;
                    if (cs_q == 3'd7) begin
                        cs_nx    = '0;
                        state_nx = S_DONE;
                    end else begin
                        cs_nx = cs_q + 3'd1;
                    end
                end else begin
                    ph_nx = ph_q + PH_W'(1);
                end
            end
            S_DONE: begin
                state_nx = S_IDLE;
            end
            default: begin
                state_nx = S_IDLE;
            end
        endcase

        // Digit nibble for the slot being entered; held stable across the slot
        upper = bcd_q >> {cs_nx, 2'b00};
        if (state_nx == S_WRITE) begin
            if (ovf_q) begin
                data4_nx = 4'hE;
            end else if ((LZ_BLANK != 0) && (upper == '0) && (cs_nx != 3'd0)) begin
                data4_nx = 4'hF;
            end else begin
                data4_nx = upper[3:0];
            end
        end

        en_nx   = (state_nx == S_WRITE) && (ph_nx != '0) && (ph_nx != PH_HOLD);
        busy_nx = (state_nx != S_IDLE);
        done_nx = (state_nx == S_DONE);
    end

    assign busy  = busy_q;
    assign done  = done_q;
    assign ovf   = ovf_q;
    assign cs    = cs_q;
    assign data4 = data4_q;
    assign en    = en_q;

endmodule

// File: tb/tb_bin_to_digit_writer.sv
// Testbench for bin_to_digit_writer. It runs one instance with default
// parameters and one with LZ_BLANK=1 side by side, models the eight display
// latches for each, and checks digits, latency, ovf, strobe rules, ignored
// starts, back-to-back operation and reset abort.
module tb_bin_to_digit_writer;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [26:0] bin_in;
    logic        busy0, done0, ovf0, en0, busy1, done1, ovf1, en1;
    logic [2:0]  cs0, cs1;
    logic [3:0]  d0, d1;

    int checks   = 0;
    int failures = 0;

    logic [31:0] lat0, lat1;
    logic [2:0]  pcs0, pcs1;
    logic [3:0]  pd0, pd1;
    int          done_cnt0, done_cnt1, en_cnt0, en_cnt1;

    typedef struct {
        logic [26:0] bin;
        logic [31:0] e0;
        logic [31:0] e1;
        logic        ovf;
    } vec_t;

    vec_t vecs[8];

    bin_to_digit_writer u_dut0 (
        .clk(clk), .rst(rst), .start(start), .bin_in(bin_in),
        .busy(busy0), .done(done0), .ovf(ovf0), .cs(cs0), .data4(d0), .en(en0)
    );

    bin_to_digit_writer #(.BIN_W(27), .EN_W(2), .LZ_BLANK(1)) u_dut1 (
        .clk(clk), .rst(rst), .start(start), .bin_in(bin_in),
        .busy(busy1), .done(done1), .ovf(ovf1), .cs(cs1), .data4(d1), .en(en1)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // One clock: sample after the edge, then apply the strobe rules and the latch model
    task automatic tick();
        @(posedge clk);
        #1;
        if (en0) begin
            chk("en0_stable", 32'({cs0, d0}), 32'({pcs0, pd0}));
            chk("en0_in_write", 32'(busy0 && !done0), 32'd1);
            lat0[cs0*4 +: 4] = d0;
            en_cnt0++;
        end
        if (en1) begin
            chk("en1_stable", 32'({cs1, d1}), 32'({pcs1, pd1}));
            chk("en1_in_write", 32'(busy1 && !done1), 32'd1);
            lat1[cs1*4 +: 4] = d1;
            en_cnt1++;
        end
        if (done0) done_cnt0++;
        if (done1) done_cnt1++;
        pcs0 = cs0; pd0 = d0;
        pcs1 = cs1; pd1 = d1;
    endtask

    task automatic clear_model();
        lat0 = 32'hAAAA_AAAA;
        lat1 = 32'hAAAA_AAAA;
        done_cnt0 = 0; done_cnt1 = 0;
        en_cnt0 = 0;   en_cnt1 = 0;
    endtask

    // Start one operation; optional extra start pulses at cycles pa/pb after accept
    task automatic run_op(input logic [26:0] b, input int pa, input int pb, output int lat);
        @(negedge clk);
        clear_model();
        bin_in = b;
        start  = 1'b1;
        tick();
        start  = 1'b0;
        bin_in = ~b;
        chk("busy_after_accept", 32'({busy0, busy1}), 32'b11);
        lat = 0;
        while (done_cnt0 == 0 && lat < 100) begin
            if ((pa != 0 && lat == pa) || (pb != 0 && lat == pb)) start = 1'b1;
            tick();
            start = 1'b0;
            lat++;
        end
    endtask

    int lat;

    initial begin
        vecs[0] = '{27'd12345678,  32'h1234_5678, 32'h1234_5678, 1'b0};
        vecs[1] = '{27'd0,         32'h0000_0000, 32'hFFFF_FFF0, 1'b0};
        vecs[2] = '{27'd100000000, 32'hEEEE_EEEE, 32'hEEEE_EEEE, 1'b1};
        vecs[3] = '{27'd99999999,  32'h9999_9999, 32'h9999_9999, 1'b0};
        vecs[4] = '{27'd5,         32'h0000_0005, 32'hFFFF_FFF5, 1'b0};
        vecs[5] = '{27'd1000,      32'h0000_1000, 32'hFFFF_1000, 1'b0};
        vecs[6] = '{27'h7FF_FFFF,  32'hEEEE_EEEE, 32'hEEEE_EEEE, 1'b1};
        vecs[7] = '{27'd10000000,  32'h1000_0000, 32'h1000_0000, 1'b0};

        rst = 1'b1; start = 1'b0; bin_in = '0;
        pcs0 = '0; pd0 = '0; pcs1 = '0; pd1 = '0;
        clear_model();
        repeat (3) tick();
        chk("reset_outs0", 32'({busy0, done0, ovf0, cs0, d0, en0}), 32'd0);
        chk("reset_outs1", 32'({busy1, done1, ovf1, cs1, d1, en1}), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        tick();

        // Table-driven conversions
        for (int i = 0; i < 8; i++) begin
            run_op(vecs[i].bin, 0, 0, lat);
            chk("latency", 32'(lat), 32'd60);
            chk("done1_aligned", 32'(done1), 32'd1);
            chk("ovf0", 32'(ovf0), 32'(vecs[i].ovf));
            chk("ovf1", 32'(ovf1), 32'(vecs[i].ovf));
            chk("digits0", lat0, vecs[i].e0);
            chk("digits1", lat1, vecs[i].e1);
            chk("strobes0", 32'(en_cnt0), 32'd16);
            chk("strobes1", 32'(en_cnt1), 32'd16);
            tick();
            chk("idle_after_done", 32'({busy0, done0, busy1, done1}), 32'd0);
        end

        // Extra start pulses during CONV and WRITE are ignored
        run_op(27'd87654321, 10, 45, lat);
        chk("ign_latency", 32'(lat), 32'd60);
        chk("ign_digits", lat0, 32'h8765_4321);
        repeat (80) tick();
        chk("ign_one_done", 32'(done_cnt0), 32'd1);

        // start held high: back-to-back with exactly one IDLE cycle between
        @(negedge clk);
        clear_model();
        bin_in = 27'd11111111;
        start  = 1'b1;
        tick();
        lat = 0;
        while (done_cnt0 == 0 && lat < 100) begin tick(); lat++; end
        chk("b2b_first_lat", 32'(lat), 32'd60);
        chk("b2b_first_digits", lat0, 32'h1111_1111);
        bin_in = 27'd22222222;
        lat0 = 32'hAAAA_AAAA;
        tick(); lat++;
        chk("b2b_idle_gap", 32'({busy0, done0}), 32'd0);
        tick(); lat++;
        chk("b2b_reaccept", 32'(busy0), 32'd1);
        start = 1'b0;
        while (done_cnt0 < 2 && lat < 200) begin tick(); lat++; end
        chk("b2b_second_lat", 32'(lat), 32'd122);
        chk("b2b_second_digits", lat0, 32'h2222_2222);
        tick();

        // Reset during the digit 3 strobe aborts; earlier digits stay latched
        @(negedge clk);
        clear_model();
        bin_in = 27'd12345678;
        start  = 1'b1;
        tick();
        start = 1'b0;
        lat = 0;
        while (lat < 41) begin tick(); lat++; end
        chk("abort_at_strobe", 32'({en0, cs0}), 32'({1'b1, 3'd3}));
        rst = 1'b1;
        tick();
        chk("abort_outs", 32'({en0, cs0, busy0, done0}), 32'd0);
        rst = 1'b0;
        repeat (80) tick();
        chk("abort_no_done", 32'(done_cnt0), 32'd0);
        chk("abort_partial", lat0, 32'hAAAA_5678);

        // Normal operation after the abort
        run_op(27'd4321, 0, 0, lat);
        chk("post_abort_lat", 32'(lat), 32'd60);
        chk("post_abort_digits0", lat0, 32'h0000_4321);
        chk("post_abort_digits1", lat1, 32'hFFFF_4321);
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
